// File: rtl/gauss_line_buffer.sv
// Two-line pixel buffer presenting a vertically aligned 3-pixel column per enabled clock.
// Optional start-of-frame input enabled by defining GAUSS_LINE_BUFFER_SOF_EN.
module gauss_line_buffer #(
    parameter int N  = 8,
    parameter int W  = 64,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
`ifdef GAUSS_LINE_BUFFER_SOF_EN
    input  logic          sof,
`endif
    input  logic [N-1:0]  d,
    output logic [N-1:0]  q0,
    output logic [N-1:0]  q1,
    output logic [N-1:0]  q2,
    output logic          q_valid,
    output logic [AW-1:0] col,
    output logic          rows_ready
);

    typedef enum logic [1:0] {
        LC_NONE = 2'd0,
        LC_ONE  = 2'd1,
        LC_TWO  = 2'd2
    } line_cnt_t;

    logic [N-1:0]  r_mem1 [0:W-1];
    logic [N-1:0]  r_mem2 [0:W-1];

    logic [AW-1:0] r_wp;
    line_cnt_t     r_lines;

    logic          w_sof;
    logic [AW-1:0] w_wp_eff;
    logic          w_last;
    logic [AW-1:0] w_wp_next;
    line_cnt_t     w_lines_next;

`ifdef GAUSS_LINE_BUFFER_SOF_EN
    always_comb w_sof = ce & sof;
`else
    always_comb w_sof = 1'b0;
`endif

    // A start-of-frame pixel is written as column 0 regardless of the current pointer.
    always_comb begin
        w_wp_eff = w_sof ? '0 : r_wp;
        w_last   = (w_wp_eff == AW'(W - 1));
        w_wp_next = w_last ? '0 : w_wp_eff + AW'(1);
    end

    always_comb begin
        w_lines_next = r_lines;
        if (ce) begin
            if (w_sof) begin
                w_lines_next = LC_NONE;
            end
            if (w_last) begin
                unique case (w_lines_next)
                    LC_NONE: w_lines_next = LC_ONE;
                    LC_ONE:  w_lines_next = LC_TWO;
                    default: w_lines_next = LC_TWO;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_lines <= LC_NONE;
        end else if (ce) begin
            r_wp    <= w_wp_next;
            r_lines <= w_lines_next;
        end
    end

    // Line memories carry no reset so they map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (ce) begin
            r_mem1[w_wp_eff] <= d;
            r_mem2[w_wp_eff] <= r_mem1[w_wp_eff];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0         <= '0;
            q1         <= '0;
            q2         <= '0;
            q_valid    <= 1'b0;
            col        <= '0;
            rows_ready <= 1'b0;
        end else begin
            q_valid <= ce;
            if (ce) begin
                q0         <= d;
                q1         <= r_mem1[w_wp_eff];
                q2         <= r_mem2[w_wp_eff];
                col        <= w_wp_eff;
                rows_ready <= (w_lines_next == LC_TWO);
            end
        end
    end

endmodule

// File: tb/tb_gauss_line_buffer.sv
// Directed bench for gauss_line_buffer: a frame-history model checked every cycle
// plus hand-computed literal expectations; W=4 main instance, W=5 wrap instance.
module tb_gauss_line_buffer;

    localparam int W4 = 4;
    localparam int W5 = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce = 1'b0;
    logic       sof = 1'b0;
    logic [7:0] d = '0;
    logic [7:0] q0, q1, q2;
    logic       q_valid, rows_ready;
    logic [1:0] col;

    logic       ce5 = 1'b0;
    logic       sof5 = 1'b0;
    logic [7:0] d5 = '0;
    logic [7:0] q0_5, q1_5, q2_5;
    logic       q_valid5, rows_ready5;
    logic [2:0] col5;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    gauss_line_buffer #(.N(8), .W(W4), .AW(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .ce(ce),
`ifdef GAUSS_LINE_BUFFER_SOF_EN
        .sof(sof),
`endif
        .d(d), .q0(q0), .q1(q1), .q2(q2), .q_valid(q_valid),
        .col(col), .rows_ready(rows_ready)
    );

    gauss_line_buffer #(.N(8), .W(W5), .AW(3)) dut5 (
        .clk(clk), .rst_n(rst_n), .ce(ce5),
`ifdef GAUSS_LINE_BUFFER_SOF_EN
        .sof(sof5),
`endif
        .d(d5), .q0(q0_5), .q1(q1_5), .q2(q2_5), .q_valid(q_valid5),
        .col(col5), .rows_ready(rows_ready5)
    );

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: every pixel accepted since reset or start of frame, in order.
    logic [7:0]  hist [0:63];
    int unsigned m_cnt = 0;
    logic        m_valid = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt   <= 0;
            m_valid <= 1'b0;
        end else begin
            m_valid <= ce;
            if (ce) begin
                if (sof) begin
                    hist[0] <= d;
                    m_cnt   <= 1;
                end else if (m_cnt < 64) begin
                    hist[m_cnt] <= d;
                    m_cnt       <= m_cnt + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            automatic int unsigned k;
            chk("q_valid", q_valid, m_valid);
            chk("rows_ready", rows_ready, (m_cnt >= 2 * W4) ? 1 : 0);
            if (m_cnt == 0) begin
                chk("q0_rst", q0, 0);
                chk("q1_rst", q1, 0);
                chk("q2_rst", q2, 0);
                chk("col_rst", col, 0);
            end else begin
                k = m_cnt - 1;
                chk("q0", q0, hist[k]);
                chk("col", col, k % W4);
                if (k >= W4)     chk("q1", q1, hist[k - W4]);
                if (k >= 2 * W4) chk("q2", q2, hist[k - 2 * W4]);
            end
        end
    end

    // Called just after a falling edge; returns just after a falling edge.
    task automatic feed(input int unsigned v, input int unsigned gap, input bit s);
        ce = 1'b1; d = 8'(v); sof = s;
        @(negedge clk);
        ce = 1'b0; sof = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic stream_1_to_12(input int unsigned gap);
        for (int unsigned v = 1; v <= 12; v++) begin
            feed(v, gap, 1'b0);
            chk("s_q0", q0, v);
            if (v == 7) chk("s_rr_before", rows_ready, 0);
            if (v == 8) chk("s_rr_rise", rows_ready, 1);
            if (v == 9) begin
                chk("s_p9_q1", q1, 5);
                chk("s_p9_q2", q2, 1);
                chk("s_p9_col", col, 0);
            end
            if (v == 12) begin
                chk("s_p12_q1", q1, 8);
                chk("s_p12_q2", q2, 4);
            end
        end
    endtask

    initial begin
        int unsigned exp5 [15];
        exp5 = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2, 3, 4};

        // Reset release with ce idle.
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("idle_q_valid", q_valid, 0);
            chk("idle_rows_ready", rows_ready, 0);
        end

        // Continuous stream.
        stream_1_to_12(0);

        // Same stream with 3-cycle gaps after each pixel.
        do_reset();
        stream_1_to_12(3);

        // Asynchronous reset mid-line, then restream.
        do_reset();
        for (int unsigned v = 1; v <= 6; v++) feed(v, 0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_q0", q0, 0);
        chk("arst_q1", q1, 0);
        chk("arst_q2", q2, 0);
        chk("arst_q_valid", q_valid, 0);
        chk("arst_col", col, 0);
        chk("arst_rows_ready", rows_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int unsigned v = 1; v <= 8; v++) begin
            feed(20 + v, 0, 1'b0);
            if (v == 1) chk("rs_first_col", col, 0);
            if (v == 7) chk("rs_rr_before", rows_ready, 0);
            if (v == 8) chk("rs_rr_rise", rows_ready, 1);
        end

        // Column wrap on the W=5 instance.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            ce5 = 1'b1; d5 = 8'(100 + i);
            @(negedge clk);
            chk("w5_col", col5, exp5[i]);
            chk("w5_q0", q0_5, 100 + i);
            chk("w5_q_valid", q_valid5, 1);
        end
        ce5 = 1'b0;
        @(negedge clk);
        chk("w5_q_valid_off", q_valid5, 0);

`ifdef GAUSS_LINE_BUFFER_SOF_EN
        // Start of frame mid-line.
        do_reset();
        for (int unsigned v = 1; v <= 10; v++) feed(v, 0, 1'b0);
        chk("sof_rr_pre", rows_ready, 1);
        feed(50, 0, 1'b1);
        chk("sof_col", col, 0);
        chk("sof_q0", q0, 50);
        chk("sof_rr_drop", rows_ready, 0);
        for (int unsigned v = 1; v <= 7; v++) begin
            feed(50 + v, 0, 1'b0);
            if (v == 6) chk("sof_rr_before", rows_ready, 0);
            if (v == 7) chk("sof_rr_rise", rows_ready, 1);
        end
        // sof without ce must be ignored.
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
        feed(70, 0, 1'b0);
        chk("sof_idle_col", col, 0);
        chk("sof_idle_rr", rows_ready, 1);
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
